// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter:
// FSM encoding, hold-counter sizing and one-hot to binary encoding.
package ring_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Hold counter needs at least one bit even when MAX_HOLD is 1 or 2.
    function automatic int cnt_width(input int max_hold);
        return ($clog2(max_hold) < 1) ? 1 : $clog2(max_hold);
    endfunction

    // Vectors up to 32 bits wide; the caller zero-extends and truncates.
    function automatic logic [31:0] onehot_to_bin(input logic [31:0] oh);
        logic [31:0] idx;
        idx = 32'd0;
        for (int i = 0; i < 32; i++) begin
            idx = idx | (oh[i] ? 32'(i) : 32'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational circular priority select: first request at or above the
// one-hot token, wrapping from N-1 back to 0.
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] win,
    output logic         any
);

    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    logic [N-1:0]   thermo_s;
    logic [2*N-1:0] dbl_s;
    logic [2*N-1:0] iso_s;

    // Upper copy is unmasked so requests below the token are found after wrap.
    always_comb begin
        thermo_s = ~(ptr - ONE_N);
        dbl_s    = {req, req & thermo_s};
        iso_s    = dbl_s & (~dbl_s + ONE_2N);
        win      = iso_s[N-1:0] | iso_s[2*N-1:N];
        any      = |req;
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating token, registered one-hot
// grant, one bubble between grants and a bounded hold time.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         ptr
);

    localparam int IDW = $clog2(N);
    localparam int CW  = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0]  HOLD_ONE  = CW'(1);
    localparam logic [CW-1:0]  HOLD_ZERO = CW'(0);
    localparam logic [N-1:0]   PTR_RST   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   VEC_ZERO  = {N{1'b0}};
    localparam logic [IDW-1:0] ID_ZERO   = {IDW{1'b0}};

    arb_state_e     state_r, state_s;
    logic [CW-1:0]  hold_r, hold_s;
    logic [N-1:0]   ptr_r, ptr_s;
    logic [N-1:0]   grant_r, grant_s;
    logic           valid_r, valid_s;
    logic [IDW-1:0] id_r, id_s;
    logic [N-1:0]   win_s;
    logic           any_s;
    logic           release_s;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr_r),
        .win (win_s),
        .any (any_s)
    );

    // Next-state, hold counter, token rotation and output register inputs.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        ptr_s     = ptr_r;
        grant_s   = grant_r;
        valid_s   = valid_r;
        id_s      = id_r;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    grant_s = win_s;
                    valid_s = 1'b1;
                    id_s    = IDW'(onehot_to_bin(32'(win_s)));
                    hold_s  = HOLD_ZERO;
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                release_s = ~|(req & grant_r) | (hold_r == HOLD_LAST);
                if (release_s) begin
                    grant_s = VEC_ZERO;
                    valid_s = 1'b0;
                    id_s    = ID_ZERO;
                    ptr_s   = {grant_r[N-2:0], grant_r[N-1]};
                    state_s = ST_IDLE;
                end else begin
                    hold_s  = hold_r + HOLD_ONE;
                    state_s = ST_GRANT;
                end
            end
            default: begin
                grant_s = VEC_ZERO;
                valid_s = 1'b0;
                id_s    = ID_ZERO;
                hold_s  = HOLD_ZERO;
                ptr_s   = PTR_RST;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            hold_r  <= HOLD_ZERO;
            ptr_r   <= PTR_RST;
            grant_r <= VEC_ZERO;
            valid_r <= 1'b0;
            id_r    <= ID_ZERO;
        end else begin
            state_r <= state_s;
            hold_r  <= hold_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            valid_r <= valid_s;
            id_r    <= id_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = valid_r;
    assign grant_id    = id_r;
    assign ptr         = ptr_r;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: cycle-level behavioural model
// compared every cycle, plus directed literal checks for each scenario.
module tb_ring_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [N-1:0] ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index, cycles already granted, token position.
    int m_busy  = 0;
    int m_g     = 0;
    int m_cnt   = 0;
    int m_pos   = 0;
    int chk_en  = 0;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .ptr         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Behavioural model advanced on each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 0;
            m_g    <= 0;
            m_cnt  <= 0;
            m_pos  <= 0;
            chk_en <= 1;
        end else if (m_busy == 0) begin
            if (req != '0) begin
                m_busy <= 1;
                m_g    <= pick(req, m_pos);
                m_cnt  <= 1;
            end
        end else if (!req[m_g] || m_cnt == MAX_HOLD) begin
            m_busy <= 0;
            m_pos  <= (m_g + 1) % N;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ep;
        logic [1:0]   eid;
        logic         ev;
        if (chk_en != 0) begin
            eg  = (m_busy != 0) ? N'(1 << m_g) : '0;
            ev  = (m_busy != 0);
            eid = (m_busy != 0) ? 2'(m_g) : 2'd0;
            ep  = N'(1 << m_pos);
            n_tests++;
            if (grant !== eg || grant_valid !== ev || grant_id !== eid || ptr !== ep) begin
                n_fail++;
                $display("FAIL model t=%0t: got grant=%b valid=%b id=%0d ptr=%b, want grant=%b valid=%b id=%0d ptr=%b",
                         $time, grant, grant_valid, grant_id, ptr, eg, ev, eid, ep);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b1111;
        // Reset held for two edges with all requests active.
        step(1);
        check("rst_grant1", 32'(grant), 32'h0);
        step(1);
        check("rst_grant2", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_id", 32'(grant_id), 32'h0);
        check("rst_ptr", 32'(ptr), 32'h1);
        rst = 1'b1;
        step(1);
        check("first_grant", 32'(grant), 32'h1);

        // Full load: 8-cycle grants separated by single bubbles.
        step(7);
        check("load_g0_last", 32'(grant), 32'h1);
        step(1);
        check("load_bub0", 32'(grant), 32'h0);
        check("load_ptr0", 32'(ptr), 32'h2);
        step(1);
        check("load_g1", 32'(grant), 32'h2);
        check("load_id1", 32'(grant_id), 32'h1);
        step(8);
        check("load_ptr1", 32'(ptr), 32'h4);
        step(1);
        check("load_g2", 32'(grant), 32'h4);
        step(8);
        check("load_ptr2", 32'(ptr), 32'h8);
        step(1);
        check("load_g3", 32'(grant), 32'h8);
        step(8);
        check("load_ptr3", 32'(ptr), 32'h1);
        step(1);
        check("load_g0_again", 32'(grant), 32'h1);

        // Early release after three cycles.
        rst = 1'b0;
        req = 4'b0000;
        step(1);
        rst = 1'b1;
        req = 4'b0100;
        step(1);
        check("early_g", 32'(grant), 32'h4);
        check("early_id", 32'(grant_id), 32'h2);
        step(2);
        check("early_g3", 32'(grant), 32'h4);
        req = 4'b0000;
        step(1);
        check("early_drop", 32'(grant), 32'h0);
        check("early_ptr", 32'(ptr), 32'h8);
        check("early_valid", 32'(grant_valid), 32'h0);

        // Wrap from token 3 to requester 0, then requester 1.
        req = 4'b0011;
        step(1);
        check("wrap_g0", 32'(grant), 32'h1);
        step(8);
        check("wrap_bub", 32'(grant), 32'h0);
        check("wrap_ptr", 32'(ptr), 32'h2);
        step(1);
        check("wrap_g1", 32'(grant), 32'h2);
        req = 4'b0000;
        step(1);
        check("wrap_end_ptr", 32'(ptr), 32'h4);

        // Sole hog re-granted after each bubble.
        rst = 1'b0;
        req = 4'b0010;
        step(1);
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            step(1);
            check("hog_first", 32'(grant), 32'h2);
            step(7);
            check("hog_last", 32'(grant), 32'h2);
            step(1);
            check("hog_bub", 32'(grant), 32'h0);
            check("hog_ptr", 32'(ptr), 32'h4);
        end

        // Reset in the middle of a grant.
        rst = 1'b0;
        req = 4'b0000;
        step(1);
        rst = 1'b1;
        req = 4'b0100;
        step(2);
        check("mid_pre", 32'(grant), 32'h4);
        rst = 1'b0;
        req = 4'b1111;
        step(1);
        check("mid_grant", 32'(grant), 32'h0);
        check("mid_ptr", 32'(ptr), 32'h1);
        rst = 1'b1;
        step(1);
        check("mid_regrant", 32'(grant), 32'h1);
        req = 4'b0000;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
